inst_sram_loader: RTL and testbench

//  Boot-time program loader upstream of mycpu_top. Accepts 32-bit machine-code words on a

---
 rtl/inst_sram_loader.sv | 91 +++++++++
 tb/tb_inst_sram_loader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/inst_sram_loader.sv
// inst_sram_loader: boot-time loader streaming program words into instruction SRAM, then releasing the CPU
//   in:  clk, reset (sync, active-high), start pulse, load_valid/load_data/load_last stream
//   out: load_ready, inst_sram_wen/waddr/wdata write port, inst_sram_en_toif, cpu_reset,
//        busy (LOAD/DRAIN), done (RUN), err_overflow (sticky), word_count
module inst_sram_loader #(
  parameter logic [63:0] BASE_ADDR = 64'd1,
  parameter int MAX_WORDS = 1024,
  parameter int RELEASE_DELAY = 2,
  localparam int CW = $clog2(MAX_WORDS + 1),
  localparam int DW = $clog2(RELEASE_DELAY + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  output logic          load_ready,
  output logic          inst_sram_wen,
  output logic [63:0]   inst_sram_waddr,
  output logic [31:0]   inst_sram_wdata,
  output logic          inst_sram_en_toif,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          err_overflow,
  output logic [CW-1:0] word_count
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, RUN} state_e;
  state_e state_q;
  logic [DW-1:0] dly_q;
  logic accept;
  logic [CW-1:0] wc_inc;
  assign accept = load_valid & load_ready;
  assign wc_inc = word_count + 1'b1;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      dly_q             <= '0;
      load_ready        <= 1'b0;
      inst_sram_wen     <= 1'b0;
      inst_sram_waddr   <= BASE_ADDR;
      inst_sram_wdata   <= '0;
      inst_sram_en_toif <= 1'b0;
      cpu_reset         <= 1'b1;
      busy              <= 1'b0;
      done              <= 1'b0;
      err_overflow      <= 1'b0;
      word_count        <= '0;
    end else begin
      inst_sram_wen <= 1'b0;
      case (state_q)
        IDLE, RUN: if (start) begin
          state_q           <= LOAD;
          word_count        <= '0;
          err_overflow      <= 1'b0;
          load_ready        <= 1'b1;
          cpu_reset         <= 1'b1;
          inst_sram_en_toif <= 1'b0;
          busy              <= 1'b1;
          done              <= 1'b0;
        end
        LOAD: if (accept) begin
          inst_sram_wen   <= 1'b1;
          inst_sram_waddr <= BASE_ADDR + 64'(word_count);
          inst_sram_wdata <= load_data;
          word_count      <= wc_inc;
          if (load_last) begin
            state_q    <= DRAIN;
            load_ready <= 1'b0;
            dly_q      <= '0;
          end else if (wc_inc == CW'(MAX_WORDS)) begin
            // capacity exhausted without a last word: abort, CPU stays in reset
            state_q      <= IDLE;
            load_ready   <= 1'b0;
            err_overflow <= 1'b1;
            busy         <= 1'b0;
          end
        end
        DRAIN: if (dly_q == DW'(RELEASE_DELAY)) begin
          // first DRAIN cycle is the final write itself, so RELEASE_DELAY idle cycles follow it
          state_q           <= RUN;
          cpu_reset         <= 1'b0;
          inst_sram_en_toif <= 1'b1;
          busy              <= 1'b0;
          done              <= 1'b1;
        end else dly_q <= dly_q + 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_sram_loader.sv
// tb_inst_sram_loader: directed table and sequence checks of inst_sram_loader
module tb_inst_sram_loader;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [31:0] load_data = '0;
  logic load_ready, wen, en_toif, cpu_reset, busy, done, err;
  logic [63:0] waddr;
  logic [31:0] wdata;
  logic [10:0] wc;
  logic s_ready, s_wen, s_en, s_crst, s_busy, s_done, s_err;
  logic [63:0] s_waddr;
  logic [31:0] s_wdata;
  logic [2:0] s_wc;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  inst_sram_loader dut (
    .clk(clk), .reset(reset), .start(start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .inst_sram_wen(wen), .inst_sram_waddr(waddr),
    .inst_sram_wdata(wdata), .inst_sram_en_toif(en_toif), .cpu_reset(cpu_reset), .busy(busy),
    .done(done), .err_overflow(err), .word_count(wc)
  );

  inst_sram_loader #(.MAX_WORDS(4)) dut_s (
    .clk(clk), .reset(reset), .start(start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(s_ready), .inst_sram_wen(s_wen), .inst_sram_waddr(s_waddr),
    .inst_sram_wdata(s_wdata), .inst_sram_en_toif(s_en), .cpu_reset(s_crst), .busy(s_busy),
    .done(s_done), .err_overflow(s_err), .word_count(s_wc)
  );

  typedef struct {
    logic st, vl, ls;
    logic [31:0] d;
    logic e_wen;
    logic [63:0] e_addr;
    logic [31:0] e_data;
    logic e_rdy, e_crst;
  } vec_t;
  vec_t tv[17];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic vl, input logic ls, input logic [31:0] d);
    start = st; load_valid = vl; load_last = ls; load_data = d;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " cpu_reset"}, 64'(cpu_reset), 64'd1);
    chk({tag, " en_toif"}, 64'(en_toif), 64'd0);
    chk({tag, " wen"}, 64'(wen), 64'd0);
    chk({tag, " waddr"}, waddr, 64'd1);
    chk({tag, " wdata"}, 64'(wdata), 64'd0);
    chk({tag, " ready"}, 64'(load_ready), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " err"}, 64'(err), 64'd0);
    chk({tag, " wc"}, 64'(wc), 64'd0);
  endtask

  function automatic logic [31:0] word(input int i);
    return 32'h00600113 + 32'(i) * 32'h00100080;
  endfunction

  initial begin
    // test 1: reset held 3 cycles
    drive(0, 0, 0, 0);
    reset = 1'b1;
    repeat (3) step();
    chk_reset_vals("t1");
    reset = 1'b0;

    // test 2: 18 back-to-back words
    drive(1, 0, 0, 0); step();
    chk("t2 ready_after_start", 64'(load_ready), 64'd1);
    chk("t2 busy_after_start", 64'(busy), 64'd1);
    for (int i = 0; i < 18; i++) begin
      drive(0, 1, i == 17, word(i)); step();
      chk($sformatf("t2 wen[%0d]", i), 64'(wen), 64'd1);
      chk($sformatf("t2 waddr[%0d]", i), waddr, 64'(i + 1));
      chk($sformatf("t2 wdata[%0d]", i), 64'(wdata), 64'(word(i)));
      chk($sformatf("t2 ready[%0d]", i), 64'(load_ready), 64'(i != 17));
      chk($sformatf("t2 crst[%0d]", i), 64'(cpu_reset), 64'd1);
    end
    drive(0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("t2 drain_wen[%0d]", k), 64'(wen), 64'd0);
      chk($sformatf("t2 drain_crst[%0d]", k), 64'(cpu_reset), 64'(k < 3));
      chk($sformatf("t2 drain_en[%0d]", k), 64'(en_toif), 64'(k == 3));
      chk($sformatf("t2 drain_done[%0d]", k), 64'(done), 64'(k == 3));
    end
    chk("t2 wc", 64'(wc), 64'd18);
    chk("t2 busy_run", 64'(busy), 64'd0);

    // tests 3 and 5: bubbled stream, then restart from RUN
    tv[0]  = '{1, 0, 0, 32'h0,        0, 64'd1, 32'h0,        1, 1};
    tv[1]  = '{0, 1, 0, 32'hAAAA0001, 1, 64'd1, 32'hAAAA0001, 1, 1};
    tv[2]  = '{0, 0, 0, 32'h0,        0, 64'd1, 32'hAAAA0001, 1, 1};
    tv[3]  = '{0, 1, 0, 32'hBBBB0002, 1, 64'd2, 32'hBBBB0002, 1, 1};
    tv[4]  = '{0, 0, 0, 32'h0,        0, 64'd2, 32'hBBBB0002, 1, 1};
    tv[5]  = '{0, 1, 0, 32'hCCCC0003, 1, 64'd3, 32'hCCCC0003, 1, 1};
    tv[6]  = '{0, 0, 1, 32'h0,        0, 64'd3, 32'hCCCC0003, 1, 1};
    tv[7]  = '{0, 1, 1, 32'hDDDD0004, 1, 64'd4, 32'hDDDD0004, 0, 1};
    tv[8]  = '{0, 0, 0, 32'h0,        0, 64'd4, 32'hDDDD0004, 0, 1};
    tv[9]  = '{0, 0, 0, 32'h0,        0, 64'd4, 32'hDDDD0004, 0, 1};
    tv[10] = '{0, 0, 0, 32'h0,        0, 64'd4, 32'hDDDD0004, 0, 0};
    tv[11] = '{1, 0, 0, 32'h0,        0, 64'd4, 32'hDDDD0004, 1, 1};
    tv[12] = '{0, 1, 0, 32'hEEEE0005, 1, 64'd1, 32'hEEEE0005, 1, 1};
    tv[13] = '{0, 1, 1, 32'hFFFF0006, 1, 64'd2, 32'hFFFF0006, 0, 1};
    tv[14] = '{0, 0, 0, 32'h0,        0, 64'd2, 32'hFFFF0006, 0, 1};
    tv[15] = '{0, 0, 0, 32'h0,        0, 64'd2, 32'hFFFF0006, 0, 1};
    tv[16] = '{0, 0, 0, 32'h0,        0, 64'd2, 32'hFFFF0006, 0, 0};
    reset = 1'b1; drive(0, 0, 0, 0); step(); reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(tv[i].st, tv[i].vl, tv[i].ls, tv[i].d); step();
      chk($sformatf("tv[%0d] wen", i), 64'(wen), 64'(tv[i].e_wen));
      chk($sformatf("tv[%0d] waddr", i), waddr, tv[i].e_addr);
      chk($sformatf("tv[%0d] wdata", i), 64'(wdata), 64'(tv[i].e_data));
      chk($sformatf("tv[%0d] ready", i), 64'(load_ready), 64'(tv[i].e_rdy));
      chk($sformatf("tv[%0d] crst", i), 64'(cpu_reset), 64'(tv[i].e_crst));
      chk($sformatf("tv[%0d] en", i), 64'(en_toif), 64'(!tv[i].e_crst));
    end
    chk("t5 wc", 64'(wc), 64'd2);

    // test 4: overflow on the MAX_WORDS=4 instance
    reset = 1'b1; drive(0, 0, 0, 0); step(); reset = 1'b0;
    drive(1, 0, 0, 0); step();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, word(i)); step();
      chk($sformatf("t4 wen[%0d]", i), 64'(s_wen), 64'(i < 4));
      chk($sformatf("t4 waddr[%0d]", i), s_waddr, 64'(i < 4 ? i + 1 : 4));
      chk($sformatf("t4 ready[%0d]", i), 64'(s_ready), 64'(i < 3));
      chk($sformatf("t4 crst[%0d]", i), 64'(s_crst), 64'd1);
      chk($sformatf("t4 en[%0d]", i), 64'(s_en), 64'd0);
    end
    drive(0, 0, 0, 0);
    chk("t4 err", 64'(s_err), 64'd1);
    chk("t4 wc", 64'(s_wc), 64'd4);
    chk("t4 busy", 64'(s_busy), 64'd0);
    chk("t4 done", 64'(s_done), 64'd0);

    // test 6: reset mid-load, start ignored in LOAD
    reset = 1'b1; step(); reset = 1'b0;
    drive(1, 0, 0, 0); step();
    for (int i = 0; i < 3; i++) begin
      drive(i == 1, 1, 0, word(i)); step();
      chk($sformatf("t6 waddr[%0d]", i), waddr, 64'(i + 1));
      chk($sformatf("t6 wc[%0d]", i), 64'(wc), 64'(i + 1));
    end
    reset = 1'b1; drive(0, 1, 0, word(3)); step(); reset = 1'b0;
    chk_reset_vals("t6 rst");
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, k == 1, word(4 + k)); step();
      chk($sformatf("t6 idle_wen[%0d]", k), 64'(wen), 64'd0);
      chk($sformatf("t6 idle_ready[%0d]", k), 64'(load_ready), 64'd0);
      chk($sformatf("t6 idle_wc[%0d]", k), 64'(wc), 64'd0);
      chk($sformatf("t6 idle_crst[%0d]", k), 64'(cpu_reset), 64'd1);
    end
    drive(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
